credit_accumulator: RTL and testbench

Parametrised credit register for the vending machine. It replaces the fixed 3-bit load-only sum register with a saturating coin accumulator and a vend/cancel controller. Change is paid out through a valid/ready handshake. It sits between the coin acceptor front-end and the dispense/change actuators.

---
 rtl/credit_accumulator.sv | 152 +++++++++++++++
 tb/tb_credit_accumulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_accumulator.sv
// Vending machine credit register: saturating coin accumulator, vend/cancel
// controller and change payout over a valid/ready handshake.
module credit_accumulator #(
    parameter int SUM_W      = 8,
    parameter int MAX_CREDIT = (1 << SUM_W) - 1,
    parameter int CHG_UNIT   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_coin_vld,
    input  logic [SUM_W-1:0] i_coin_val,
    input  logic [SUM_W-1:0] i_price,
    input  logic             i_vend_req,
    input  logic             i_cancel,
    input  logic             i_chg_rdy,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_coin_acc,
    output logic             o_coin_rej,
    output logic             o_dispense,
    output logic             o_short,
    output logic             o_chg_vld,
    output logic [SUM_W-1:0] o_chg_amt,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam logic [SUM_W:0] LP_MAX = (SUM_W + 1)'(MAX_CREDIT);

    // A token can never exceed the credit held, so clamping here is lossless.
    localparam int LP_CHG_I = (CHG_UNIT > MAX_CREDIT) ? MAX_CREDIT : CHG_UNIT;
    localparam logic [SUM_W-1:0] LP_CHG = SUM_W'(LP_CHG_I);

    state_t           r_state;
    logic [SUM_W-1:0] r_sum;
    logic             r_coin_acc;
    logic             r_coin_rej;
    logic             r_dispense;
    logic             r_short;
    logic             r_chg_vld;
    logic [SUM_W-1:0] r_chg_amt;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [SUM_W-1:0] w_sum_nxt;
    logic             w_acc;
    logic             w_rej;
    logic             w_short;
    logic [SUM_W:0]   w_coin_sum;
    logic [SUM_W-1:0] w_chg_amt_nxt;

    function automatic logic [SUM_W-1:0] f_token(input logic [SUM_W-1:0] a);
        f_token = (a < LP_CHG) ? a : LP_CHG;
    endfunction

    // Extra bit keeps the saturation test free of wraparound.
    assign w_coin_sum = {1'b0, r_sum} + {1'b0, i_coin_val};

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_acc       = 1'b0;
        w_rej       = 1'b0;
        w_short     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cancel) begin
                    w_rej = i_coin_vld;
                    if (r_sum != '0) begin
                        w_state_nxt = ST_CHANGE;
                    end
                end else if (i_vend_req) begin
                    w_rej = i_coin_vld;
                    if (r_sum >= i_price) begin
                        w_sum_nxt   = r_sum - i_price;
                        w_state_nxt = ST_VEND;
                    end else begin
                        w_short = 1'b1;
                    end
                end else if (i_coin_vld) begin
                    if (w_coin_sum <= LP_MAX) begin
                        w_sum_nxt = w_coin_sum[SUM_W-1:0];
                        w_acc     = 1'b1;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                w_rej       = i_coin_vld;
                w_state_nxt = (r_sum != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                w_rej = i_coin_vld;
                if (i_chg_rdy) begin
                    w_sum_nxt = r_sum - r_chg_amt;
                    if (r_sum == r_chg_amt) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_chg_amt_nxt = '0;
        if (w_state_nxt == ST_CHANGE) begin
            w_chg_amt_nxt = f_token(w_sum_nxt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_sum      <= '0;
            r_coin_acc <= 1'b0;
            r_coin_rej <= 1'b0;
            r_dispense <= 1'b0;
            r_short    <= 1'b0;
            r_chg_vld  <= 1'b0;
            r_chg_amt  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_coin_acc <= w_acc;
            r_coin_rej <= w_rej;
            r_dispense <= (w_state_nxt == ST_VEND);
            r_short    <= w_short;
            r_chg_vld  <= (w_state_nxt == ST_CHANGE);
            r_chg_amt  <= w_chg_amt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_sum      = r_sum;
    assign o_coin_acc = r_coin_acc;
    assign o_coin_rej = r_coin_rej;
    assign o_dispense = r_dispense;
    assign o_short    = r_short;
    assign o_chg_vld  = r_chg_vld;
    assign o_chg_amt  = r_chg_amt;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_credit_accumulator.sv
// Bench for credit_accumulator: two instances (change unit 1 and 4) share
// stimulus and are each checked against an integer reference model.
module tb_credit_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv;
    logic [7:0] cval;
    logic [7:0] pr;
    logic       vr;
    logic       cn;
    logic       rdy;

    logic [7:0] o_sum1, o_amt1, o_sum4, o_amt4;
    logic o_acc1, o_rej1, o_disp1, o_short1, o_vld1, o_busy1;
    logic o_acc4, o_rej4, o_disp4, o_short4, o_vld4, o_busy4;

    int n_chk  = 0;
    int n_fail = 0;

    // model: phase 0 idle, 1 vending, 2 paying change
    int ph[2], ms[2];
    int e_acc[2], e_rej[2], e_disp[2], e_short[2];
    int e_vld[2], e_amt[2], e_busy[2];

    always #5 clk = ~clk;

    credit_accumulator #(.SUM_W(8), .MAX_CREDIT(255), .CHG_UNIT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_coin_vld(cv), .i_coin_val(cval),
        .i_price(pr), .i_vend_req(vr), .i_cancel(cn), .i_chg_rdy(rdy),
        .o_sum(o_sum1), .o_coin_acc(o_acc1), .o_coin_rej(o_rej1),
        .o_dispense(o_disp1), .o_short(o_short1), .o_chg_vld(o_vld1),
        .o_chg_amt(o_amt1), .o_busy(o_busy1)
    );

    credit_accumulator #(.SUM_W(8), .MAX_CREDIT(255), .CHG_UNIT(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_coin_vld(cv), .i_coin_val(cval),
        .i_price(pr), .i_vend_req(vr), .i_cancel(cn), .i_chg_rdy(rdy),
        .o_sum(o_sum4), .o_coin_acc(o_acc4), .o_coin_rej(o_rej4),
        .o_dispense(o_disp4), .o_short(o_short4), .o_chg_vld(o_vld4),
        .o_chg_amt(o_amt4), .o_busy(o_busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input int k, input int unit);
        int coin;
        int price;
        coin  = int'(cval);
        price = int'(pr);
        e_acc[k]   = 0;
        e_rej[k]   = 0;
        e_short[k] = 0;
        if (rst) begin
            ms[k] = 0;
            ph[k] = 0;
        end else if (ph[k] == 0) begin
            if (cn) begin
                e_rej[k] = int'(cv);
                if (ms[k] > 0) ph[k] = 2;
            end else if (vr) begin
                e_rej[k] = int'(cv);
                if (ms[k] >= price) begin
                    ms[k] = ms[k] - price;
                    ph[k] = 1;
                end else begin
                    e_short[k] = 1;
                end
            end else if (cv) begin
                if (ms[k] + coin <= 255) begin
                    ms[k] = ms[k] + coin;
                    e_acc[k] = 1;
                end else begin
                    e_rej[k] = 1;
                end
            end
        end else if (ph[k] == 1) begin
            e_rej[k] = int'(cv);
            ph[k] = (ms[k] > 0) ? 2 : 0;
        end else begin
            e_rej[k] = int'(cv);
            if (rdy) begin
                ms[k] = ms[k] - imin(ms[k], unit);
                if (ms[k] == 0) ph[k] = 0;
            end
        end
        e_disp[k] = (ph[k] == 1) ? 1 : 0;
        e_vld[k]  = (ph[k] == 2) ? 1 : 0;
        e_busy[k] = (ph[k] != 0) ? 1 : 0;
        e_amt[k]  = (ph[k] == 2) ? imin(ms[k], unit) : 0;
    endtask

    task automatic compare_all();
        check("u1.sum",   32'(o_sum1),   e_sum(0));
        check("u1.acc",   32'(o_acc1),   e_acc[0]);
        check("u1.rej",   32'(o_rej1),   e_rej[0]);
        check("u1.disp",  32'(o_disp1),  e_disp[0]);
        check("u1.short", 32'(o_short1), e_short[0]);
        check("u1.vld",   32'(o_vld1),   e_vld[0]);
        check("u1.amt",   32'(o_amt1),   e_amt[0]);
        check("u1.busy",  32'(o_busy1),  e_busy[0]);
        check("u4.sum",   32'(o_sum4),   e_sum(1));
        check("u4.acc",   32'(o_acc4),   e_acc[1]);
        check("u4.rej",   32'(o_rej4),   e_rej[1]);
        check("u4.disp",  32'(o_disp4),  e_disp[1]);
        check("u4.short", 32'(o_short4), e_short[1]);
        check("u4.vld",   32'(o_vld4),   e_vld[1]);
        check("u4.amt",   32'(o_amt4),   e_amt[1]);
        check("u4.busy",  32'(o_busy4),  e_busy[1]);
    endtask

    function automatic int e_sum(input int k);
        return ms[k];
    endfunction

    task automatic cyc(input logic c_v, input int c_val, input int p,
                       input logic v, input logic c, input logic r,
                       input logic rs);
        cv   = c_v;
        cval = 8'(c_val);
        pr   = 8'(p);
        vr   = v;
        cn   = c;
        rdy  = r;
        rst  = rs;
        model_step(0, 1);
        model_step(1, 4);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, r, 1'b0);
    endtask

    task automatic coin(input int v);
        cyc(1'b1, v, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (o_busy1 || o_busy4); i++) idle(1'b1);
        check("drain_idle", 32'({o_busy1, o_busy4}), 0);
    endtask

    initial begin
        cv = 0; cval = 0; pr = 0; vr = 0; cn = 0; rdy = 0; rst = 1;
        ph = '{0, 0};
        ms = '{0, 0};

        // reset state and basic accumulation
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_sum", 32'(o_sum1), 0);
        check("rst_busy", 32'(o_busy4), 0);
        coin(5);
        check("coin5_sum", 32'(o_sum1), 5);
        check("coin5_acc", 32'(o_acc1), 1);
        coin(10);
        check("coin10_sum", 32'(o_sum4), 15);

        // saturation boundary
        coin(235);
        coin(10);
        check("sat_rej", 32'(o_rej1), 1);
        check("sat_sum", 32'(o_sum1), 250);
        coin(5);
        check("sat_full", 32'(o_sum4), 255);
        coin(0);
        check("zero_coin_acc", 32'(o_acc1), 1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // short vend, then vend with change
        coin(15);
        cyc(1'b0, 0, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        check("short_pulse", 32'(o_short1), 1);
        check("short_sum", 32'(o_sum1), 15);
        cyc(1'b0, 0, 12, 1'b1, 1'b0, 1'b0, 1'b0);
        check("vend_disp", 32'(o_disp1), 1);
        check("vend_sum", 32'(o_sum1), 3);
        idle(1'b0);
        check("vend_disp_once", 32'(o_disp1), 0);
        check("chg1_amt", 32'(o_amt1), 1);
        check("chg4_amt", 32'(o_amt4), 3);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("chg1_done_sum", 32'(o_sum1), 0);
        check("chg1_done_busy", 32'(o_busy1), 0);
        drain();

        // cancel with unit 4 and a stalled handshake
        coin(10);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cxl_vld", 32'(o_vld4), 1);
        check("cxl_amt0", 32'(o_amt4), 4);
        idle(1'b1);
        check("cxl_sum1", 32'(o_sum4), 6);
        idle(1'b0);
        check("cxl_hold_amt", 32'(o_amt4), 4);
        check("cxl_hold_vld", 32'(o_vld4), 1);
        idle(1'b1);
        check("cxl_amt2", 32'(o_amt4), 2);
        idle(1'b1);
        check("cxl_end_sum", 32'(o_sum4), 0);
        check("cxl_end_vld", 32'(o_vld4), 0);
        drain();

        // cancel beats vend and coin
        coin(8);
        cyc(1'b1, 3, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_rej", 32'(o_rej1), 1);
        check("prio_nodisp", 32'(o_disp1), 0);
        check("prio_vld", 32'(o_vld1), 1);
        check("prio_sum", 32'(o_sum1), 8);
        drain();
        check("prio_refund", 32'(o_sum1), 0);

        // coin during change, then reset mid-change
        coin(20);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("chg_coin_rej", 32'(o_rej4), 1);
        idle(1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mid_rst_sum", 32'(o_sum1), 0);
        check("mid_rst_vld", 32'(o_vld4), 0);
        check("mid_rst_busy", 32'(o_busy1), 0);
        idle(1'b1);
        check("post_rst_vld", 32'(o_vld1), 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic r_cv, r_vr, r_cn, r_rdy, r_rs;
            int   r_val, r_pr;
            r_cv  = ($urandom_range(0, 2) == 0);
            r_val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, 50);
            r_pr  = $urandom_range(0, 200);
            r_vr  = ($urandom_range(0, 7) == 0);
            r_cn  = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rs  = ($urandom_range(0, 299) == 0);
            cyc(r_cv, r_val, r_pr, r_vr, r_cn, r_rdy, r_rs);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
